// File: rtl/imem_load_pkg.sv
// Shared types and default widths for the instruction-memory load controller.
package imem_load_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Checksum is a wrapping sum over full instruction words.
  localparam int CSUM_W = DATA_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/imem_load_timer.sv
// Idle-cycle watchdog for the load phase: a down-counter reloaded on clear,
// decremented on tick, flagging terminal count at zero.
module imem_load_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Reload on clear; count down while idle, holding at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= TC_LOAD;
    end else if (clear) begin
      cnt <= TC_LOAD;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Zero means TIMEOUT-1 idle edges have already passed; the next idle edge times out.
  assign expired = (cnt == '0);

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot-time loader: streams host words into instruction memory, holds fetch
// in stall, then pulses fetch_rst for one cycle and releases fetch.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting host words, writing instruction memory
// DRAIN | last write on the load port; fetch PC reset pulse
// RUN   | load complete, fetch running; start reloads
// ERR   | load aborted on idle timeout; start reloads
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [DATA_W-1:0] load_mem_data,
  output logic              stall,
  output logic              fetch_rst,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] NUM_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] len_sel;
  logic            accept;
  logic            last_word;
  logic            start_load;
  logic            timer_clear;
  logic            timer_tick;
  logic            timer_expired;

  // Handshake, restart qualification and length sanitising.
  always_comb begin
    accept      = host_valid && (state == S_LOAD);
    last_word   = ((idx + ONE) == len);
    start_load  = start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));
    len_sel     = ((load_len == '0) || (load_len > NUM_WORDS)) ? NUM_WORDS : load_len;
    timer_clear = start_load || accept;
    timer_tick  = (state == S_LOAD) && !accept;
  end

  imem_load_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    host_ready = 1'b0;
    stall      = 1'b1;
    fetch_rst  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_load) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        host_ready = 1'b1;
        if (accept) begin
          if (last_word) state_nxt = S_DRAIN;
        end else if (timer_expired) begin
          state_nxt = S_ERR;
        end
      end
      S_DRAIN: begin
        fetch_rst = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        stall = 1'b0;
        done  = 1'b1;
        if (start_load) state_nxt = S_LOAD;
      end
      S_ERR: begin
        err = 1'b1;
        if (start_load) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word index, length latch, memory write port and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      len           <= '0;
      idx           <= '0;
      load_mem_en   <= 1'b0;
      load_mem_addr <= '0;
      load_mem_data <= '0;
      checksum      <= '0;
    end else begin
      load_mem_en <= accept;
      if (start_load) begin
        len      <= len_sel;
        idx      <= '0;
        checksum <= '0;
      end else if (accept) begin
        idx           <= idx + ONE;
        load_mem_addr <= idx[ADDR_W-1:0];
        load_mem_data <= host_data;
        checksum      <= checksum + host_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: stimulus queues expected writes, a
// negedge monitor pops and compares every presented write.
module tb_imem_load_ctrl;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              host_valid = 1'b0;
  logic [DATA_W-1:0] host_data = '0;
  logic              host_ready;
  logic              load_mem_en;
  logic [ADDR_W-1:0] load_mem_addr;
  logic [DATA_W-1:0] load_mem_data;
  logic              stall;
  logic              fetch_rst;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] checksum;

  imem_load_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .load_len      (load_len),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .load_mem_en   (load_mem_en),
    .load_mem_addr (load_mem_addr),
    .load_mem_data (load_mem_data),
    .stall         (stall),
    .fetch_rst     (fetch_rst),
    .done          (done),
    .err           (err),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               exp_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                last_wr_cyc = 0;
  int                fr_count = 0;
  logic [DATA_W-1:0] sum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented write against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (fetch_rst) begin
      fr_count++;
      check("stall_during_fetch_rst", stall, 1);
    end
    if (load_mem_en) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0h with no write expected", load_mem_addr, load_mem_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", load_mem_addr, e.a);
        check("wr_data", load_mem_data, e.d);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; c0 is the cycle index at which start was raised.
  task automatic do_start(input logic [ADDR_W:0] len, output int c0);
    start    = 1'b1;
    load_len = len;
    c0       = cyc;
    step(1);
    start    = 1'b0;
    load_len = '0;
  endtask

  // Offer n words at indexes base..base+n-1; optional idle cycle after each.
  task automatic send(input int n, input int base, input logic [DATA_W-1:0] seed, input bit gap);
    logic [DATA_W-1:0] w;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      w = seed + DATA_W'(base + i) * 32'h0102_0304;
      e.a = ADDR_W'(base + i);
      e.d = w;
      exp_q.push_back(e);
      sum = sum + w;
      host_valid = 1'b1;
      host_data  = w;
      step(1);
      if (gap) begin
        host_valid = 1'b0;
        host_data  = 32'hBAD0_BAD0;
        step(1);
      end
    end
    host_valid = 1'b0;
  endtask

  // Wait (bounded) for stall to drop; returns cycles since c0, -1 on expiry.
  task automatic wait_run(input int c0, output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall) begin
        lat = cyc - c0;
        break;
      end
    end
    check("run_reached", (lat >= 0), 1);
    check("done_in_run", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int lat;
    int fr0;
    bit seen_err;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int lat;
    int fr0;
    bit seen_err;

    // Reset with host_valid asserted; it must be ignored afterwards.
    host_valid = 1'b1;
    host_data  = 32'hDEAD_BEEF;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_stall", stall, 1);
    check("rst_done", done, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_mem_en", load_mem_en, 0);
    check("rst_fetch_rst", fetch_rst, 0);
    check("rst_err", err, 0);
    check("rst_checksum", checksum, 0);
    step(3);
    check("idle_host_ready", host_ready, 0);
    check("idle_stall", stall, 1);
    host_valid = 1'b0;

    // Full-size load via load_len = 0, back-to-back words.
    sum = '0;
    fr0 = fr_count;
    do_start(0, c0);
    check("load_host_ready", host_ready, 1);
    send(32, 0, 32'h1000_0001, 1'b0);
    wait_run(c0, lat);
    check("len32_latency", lat, 34);
    check("len32_fetch_rst_pulses", fr_count - fr0, 1);
    check("len32_checksum", checksum, sum);
    check("len32_writes_drained", exp_q.size(), 0);

    // Four words with gaps, and a start pulse in LOAD that must be ignored.
    sum = '0;
    fr0 = fr_count;
    do_start(4, c0);
    send(2, 0, 32'h2000_00A0, 1'b1);
    start    = 1'b1;
    load_len = 1;
    step(1);
    start    = 1'b0;
    load_len = '0;
    check("start_in_load_ignored", host_ready, 1);
    send(2, 2, 32'h2000_00A0, 1'b1);
    wait_run(c0, lat);
    check("len4_fetch_rst_pulses", fr_count - fr0, 1);
    check("len4_checksum", checksum, sum);
    check("len4_writes_drained", exp_q.size(), 0);

    // Restart from RUN, then stop after two words to force a timeout.
    sum = '0;
    do_start(6, c0);
    check("restart_stall", stall, 1);
    check("restart_done", done, 0);
    check("restart_host_ready", host_ready, 1);
    send(2, 0, 32'h3000_0300, 1'b0);
    seen_err = 1'b0;
    for (int k = 0; k < TIMEOUT + 50; k++) begin
      @(negedge clk);
      if (err) begin
        seen_err = 1'b1;
        break;
      end
    end
    check("timeout_err_seen", seen_err, 1);
    check("timeout_latency", cyc - last_wr_cyc, TIMEOUT);
    check("err_stall", stall, 1);
    check("err_done", done, 0);
    check("err_host_ready", host_ready, 0);
    check("err_checksum", checksum, sum);
    check("err_writes_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reload from ERR.
    sum = '0;
    fr0 = fr_count;
    do_start(3, c0);
    check("err_restart_err_clear", err, 0);
    send(3, 0, 32'h4000_4444, 1'b0);
    wait_run(c0, lat);
    check("len3_latency", lat, 5);
    check("len3_fetch_rst_pulses", fr_count - fr0, 1);
    check("len3_checksum", checksum, sum);

    // Reset mid-load after three words, host still offering data.
    sum = '0;
    do_start(8, c0);
    send(3, 0, 32'h5000_0005, 1'b0);
    host_valid = 1'b1;
    host_data  = 32'h0BAD_0BAD;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_stall", stall, 1);
    check("midrst_done", done, 0);
    check("midrst_host_ready", host_ready, 0);
    check("midrst_mem_en", load_mem_en, 0);
    check("midrst_mem_addr", load_mem_addr, 0);
    check("midrst_mem_data", load_mem_data, 0);
    check("midrst_checksum", checksum, 0);
    check("midrst_fetch_rst", fetch_rst, 0);
    check("midrst_err", err, 0);
    step(4);
    check("midrst_idle_host_ready", host_ready, 0);
    host_valid = 1'b0;
    step(2);
    check("final_writes_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-time sequencer for the instruction-fetch stage. It accepts program words from a host over a valid/ready stream and writes them into instruction memory through the fetch stage's load port (`load_mem_en` / `load_mem_addr` / `load_mem_data`). It holds the fetch stage in `stall` until loading completes, then issues a one-cycle fetch reset and releases fetch. It sits between the host interface and `instruction_fetch`, and owns every write to instruction memory.

## Interface

Parameters:
- `ADDR_W`, 5, instruction-memory word-address width; `NUM_WORDS = 2**ADDR_W`.
- `DATA_W`, 32, instruction word width.
- `TIMEOUT`, 1024, maximum number of idle cycles between accepted words while loading.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse that begins a load.
- `load_len`  in  ADDR_W+1  word count, sampled on the `start` cycle.
- `host_valid`  in  1  host word valid.
- `host_data`  in  DATA_W  host word.
- `host_ready`  out  1  controller accepts a word.
- `load_mem_en`  out  1  instruction-memory write enable.
- `load_mem_addr`  out  ADDR_W  write word address.
- `load_mem_data`  out  DATA_W  write data.
- `stall`  out  1  holds instruction fetch.
- `fetch_rst`  out  1  one-cycle, active-high PC reset for fetch.
- `done`  out  1  load completed; fetch running.
- `err`  out  1  load aborted on timeout.
- `checksum`  out  DATA_W  wrapping sum of the accepted words.

## Operation

- States: IDLE, LOAD, DRAIN, RUN, ERR.
- Outputs decoded from state:
  - `host_ready` = LOAD
  - `stall` = not RUN
  - `fetch_rst` = DRAIN
  - `done` = RUN
  - `err` = ERR
- `load_mem_*` and `checksum` are registered.
- IDLE: on `start`, go to LOAD.
  - Latch `len`: `load_len` if it is in 1..NUM_WORDS, otherwise NUM_WORDS.
  - Clear the word index, `checksum` and the timeout counter.
- LOAD: a word is accepted on an edge where `host_valid && host_ready`. On that edge:
  - `load_mem_en` is set to 1, `load_mem_addr` to the index and `load_mem_data` to `host_data`, visible in the following cycle.
  - `checksum += host_data`, mod 2^DATA_W.
  - The index increments and the timeout counter clears.
  - When the accepted word is number `len`, go to DRAIN.
  - On edges without an accept, `load_mem_en` is cleared to 0 and the timeout counter increments. When the counter reaches TIMEOUT-1 with no accept, go to ERR.
- DRAIN: exactly one cycle, in which the last write is presented. Then go to RUN.
- RUN: hold until `start`, which restarts from the IDLE-start actions and goes straight to LOAD.
- ERR: hold until `start`, which restarts the same way.
- Ignored inputs:
  - `start` is ignored in LOAD and DRAIN.
  - `host_valid` outside LOAD is ignored, since `host_ready` is 0 there.
- Index width is ADDR_W+1. The write address is the low ADDR_W bits, so a full-size load ends at address NUM_WORDS-1 with no wrap.

## Timing

- Reset values:
  - state IDLE
  - `stall` = 1
  - `load_mem_en` = 0, `load_mem_addr` = 0, `load_mem_data` = 0
  - `host_ready` = 0, `fetch_rst` = 0, `done` = 0, `err` = 0, `checksum` = 0
- Reset mid-LOAD abandons the load: no further writes, and the controller returns to IDLE.
- `start` at edge S: `host_ready` = 1 from cycle S+1.
- Word accepted at edge A: the write is visible during cycle A..A+1 and memory captures it at edge A+1.
- Last word accepted at edge N:
  - DRAIN during N..N+1, with `fetch_rst` = 1 and `stall` = 1.
  - RUN from edge N+1, with `stall` = 0 and `done` = 1.
- Throughput: one word per cycle with `host_valid` held high. A `len`-word load takes `len`+2 cycles from `start` to RUN.
- Timeout is TIMEOUT consecutive non-accept cycles in LOAD, counted from LOAD entry or from the last accept.

## Structure

- Package `imem_load_pkg` holds:
  - the state enum
  - `DATA_W` / `ADDR_W` defaults
  - the checksum width
- Sub-module `imem_load_timer` holds the timeout counter. It has `clear` and `tick` inputs and an `expired` output, and is parameterised by TIMEOUT.
- The top level holds the FSM, the index/len registers, the output registers and the checksum.

## Test plan

- Reset for 10 cycles, then release: `stall` = 1, `done` = 0, `host_ready` = 0, no `load_mem_en`, `host_valid` ignored.
- `start` with `load_len` = 0 and 32 back-to-back words:
  - 32 writes to addresses 0..31 with matching data.
  - `fetch_rst` pulses once, then `stall` goes to 0 exactly 34 cycles after `start`.
  - `checksum` equals the bench-computed sum.
- `load_len` = 4 with `host_valid` toggling every other cycle: writes occur only on accept cycles at addresses 0..3, then DRAIN then RUN.
- During LOAD, stop `host_valid` after 2 words: ERR exactly TIMEOUT cycles after the last accept, with `err` = 1 and `stall` = 1. A subsequent `start` reloads successfully.
- Assert `start` again in LOAD: it is ignored. `start` in RUN: `stall` rises the next cycle, `done` = 0, and the index restarts at 0.
- Assert `rst` mid-load after 3 words: IDLE and all outputs at reset values next cycle; no further writes.
